// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: state encoding, port indices and a small grant helper shared by
// ram_arbiter and rr_arbiter2.
package ram_arb_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRead,
      StRdWait,
      StRdDone
   } arb_state_e;

   localparam logic Port0 = 1'b0;
   localparam logic Port1 = 1'b1;

   // Port index of a one-hot two-port grant vector.
   function automatic logic onehot_to_port(input logic [1:0] gnt);
      return gnt[Port1];
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-port grant selection. Round-robin by default: on a tie the
// port not granted last wins. Defining RAM_ARB_FIXED_PRIO_EN makes port 0 win
// every tie, and the last-granted input disappears.
module rr_arbiter2
   import ram_arb_pkg::*;
(
   input  logic [1:0] req_i,
`ifndef RAM_ARB_FIXED_PRIO_EN
   input  logic       last_i,  // 1 = port 1 granted last
`endif
   output logic [1:0] gnt_o
);

   // One-hot grant from the current request pair.
   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01: gnt_o[Port0] = 1'b1;
         2'b10: gnt_o[Port1] = 1'b1;
         2'b11: begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            gnt_o[Port0] = 1'b1;
`else
            if (last_i == Port1) begin
               gnt_o[Port0] = 1'b1;
            end else begin
               gnt_o[Port1] = 1'b1;
            end
`endif
         end
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two requesters.
// Writes ack one cycle after the grant, reads three cycles after it. All
// RAM-side and requester-side outputs are registered. Optional build macro
// RAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned M = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [1:0]   req_i,
   input  logic [1:0]   we_i,
   input  logic [N-1:0] addr0_i,
   input  logic [N-1:0] addr1_i,
   input  logic [M-1:0] wdata0_i,
   input  logic [M-1:0] wdata1_i,
   output logic [1:0]   ack_o,
   output logic [M-1:0] rdata0_o,
   output logic [M-1:0] rdata1_o,
   output logic         busy_o,
   output logic [N-1:0] ram_addr_o,
   output logic [M-1:0] ram_wdata_o,
   output logic         ram_wren_o,
   output logic         ram_rden_o,
   input  logic [M-1:0] ram_rdata_i
);

   arb_state_e   state_q;
   logic         port_q;
   logic [N-1:0] addr_q;
   logic [M-1:0] wdata_q;
   logic         wren_q;
   logic         rden_q;
   logic [1:0]   ack_q;
   logic [M-1:0] rdata0_q;
   logic [M-1:0] rdata1_q;
   logic [1:0]   gnt;
   logic         gnt_port;

`ifndef RAM_ARB_FIXED_PRIO_EN
   logic         last_q;
`endif

   rr_arbiter2 u_arb (
      .req_i  (req_i),
`ifndef RAM_ARB_FIXED_PRIO_EN
      .last_i (last_q),
`endif
      .gnt_o  (gnt)
   );

   assign gnt_port = onehot_to_port(gnt);

`ifndef RAM_ARB_FIXED_PRIO_EN
   // Remember the most recent grant; reset favours port 0 for the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= Port1;
      end else if (state_q == StIdle && gnt != 2'b00) begin
         last_q <= gnt_port;
      end
   end
`endif

   // Transaction FSM; enables and acks are set on entry to their state so they
   // come straight from flops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         port_q   <= Port0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wren_q   <= 1'b0;
         rden_q   <= 1'b0;
         ack_q    <= 2'b00;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (gnt != 2'b00) begin
                  port_q  <= gnt_port;
                  addr_q  <= (gnt_port == Port1) ? addr1_i : addr0_i;
                  wdata_q <= (gnt_port == Port1) ? wdata1_i : wdata0_i;
                  if (we_i[gnt_port]) begin
                     state_q <= StWrite;
                     wren_q  <= 1'b1;
                     ack_q   <= gnt;
                  end else begin
                     state_q <= StRead;
                     rden_q  <= 1'b1;
                  end
               end
            end
            StWrite: begin
               state_q <= StIdle;
               wren_q  <= 1'b0;
               ack_q   <= 2'b00;
            end
            StRead: begin
               state_q <= StRdWait;
               rden_q  <= 1'b0;
            end
            StRdWait: begin
               // RAM data is valid now, one cycle after the read enable.
               state_q       <= StRdDone;
               ack_q[port_q] <= 1'b1;
               if (port_q == Port1) begin
                  rdata1_q <= ram_rdata_i;
               end else begin
                  rdata0_q <= ram_rdata_i;
               end
            end
            StRdDone: begin
               state_q <= StIdle;
               ack_q   <= 2'b00;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o      = (state_q != StIdle);
   assign ack_o       = ack_q;
   assign rdata0_o    = rdata0_q;
   assign rdata1_o    = rdata1_q;
   assign ram_addr_o  = addr_q;
   assign ram_wdata_o = wdata_q;
   assign ram_wren_o  = wren_q;
   assign ram_rden_o  = rden_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus random traffic for ram_arbiter,
// checked every cycle against a transaction-level model (grant rule, fixed
// write/read lengths, model memory). Honours RAM_ARB_FIXED_PRIO_EN.
module tb_ram_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned M     = 4;
   localparam int unsigned Depth = 16;
`ifdef RAM_ARB_FIXED_PRIO_EN
   localparam bit FixedPrio = 1'b1;
`else
   localparam bit FixedPrio = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_ni;
   logic [1:0]   req;
   logic [1:0]   we;
   logic [N-1:0] addr0;
   logic [N-1:0] addr1;
   logic [M-1:0] wdata0;
   logic [M-1:0] wdata1;
   logic [1:0]   ack;
   logic [M-1:0] rdata0;
   logic [M-1:0] rdata1;
   logic         busy;
   logic [N-1:0] ram_addr;
   logic [M-1:0] ram_wdata;
   logic         ram_wren;
   logic         ram_rden;
   logic [M-1:0] ram_rdata;

   logic [M-1:0] ram_mem [Depth] = '{default: '0};

   int n_vec = 0;
   int n_err = 0;

   // Transaction-level model state.
   logic [M-1:0] m_mem [Depth] = '{default: '0};
   logic [M-1:0] m_rdata [2];
   int           m_pos;   // cycle within current transaction, 0 = idle
   int           m_len;   // 1 for write, 3 for read
   logic         m_port;
   logic         m_we;
   logic         m_last;
   logic [N-1:0] m_addr;
   logic [M-1:0] m_wdata;
   logic [1:0]   m_ack;

   ram_arbiter #(.N(N), .M(M)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req_i       (req),
      .we_i        (we),
      .addr0_i     (addr0),
      .addr1_i     (addr1),
      .wdata0_i    (wdata0),
      .wdata1_i    (wdata1),
      .ack_o       (ack),
      .rdata0_o    (rdata0),
      .rdata1_o    (rdata1),
      .busy_o      (busy),
      .ram_addr_o  (ram_addr),
      .ram_wdata_o (ram_wdata),
      .ram_wren_o  (ram_wren),
      .ram_rden_o  (ram_rden),
      .ram_rdata_i (ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM, one cycle read latency.
   always @(posedge clk) begin
      if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
      if (ram_rden) ram_rdata <= ram_mem[ram_addr];
   end

   task automatic model_reset();
      m_pos      = 0;
      m_len      = 0;
      m_port     = 1'b0;
      m_we       = 1'b0;
      m_last     = 1'b1;
      m_addr     = '0;
      m_wdata    = '0;
      m_ack      = 2'b00;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
   endtask

   // Advance the model over the next rising edge, run that edge, then compare
   // every output at the following falling edge.
   task automatic step();
      logic [4:0] exp_ctl;
      if (m_pos != 0 && m_pos < m_len) begin
         m_pos++;
      end else if (m_pos != 0) begin
         m_pos = 0;
      end else if (req != 2'b00) begin
         if (req == 2'b11) m_port = FixedPrio ? 1'b0 : ~m_last;
         else              m_port = req[1];
         m_last  = m_port;
         m_we    = we[m_port];
         m_addr  = m_port ? addr1 : addr0;
         m_wdata = m_port ? wdata1 : wdata0;
         m_len   = m_we ? 1 : 3;
         m_pos   = 1;
      end
      m_ack = 2'b00;
      if (m_pos == 1 && m_we) m_mem[m_addr] = m_wdata;
      if (m_pos != 0 && m_pos == m_len) begin
         m_ack[m_port] = 1'b1;
         if (!m_we) m_rdata[m_port] = m_mem[m_addr];
      end
      exp_ctl = {m_ack, m_pos != 0, m_pos == 1 && m_we, m_pos == 1 && !m_we};
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({ack, busy, ram_wren, ram_rden} !== exp_ctl) begin
         n_err++;
         $display("FAIL ctl {ack,busy,wren,rden} at %0t: got %b want %b", $time,
                  {ack, busy, ram_wren, ram_rden}, exp_ctl);
      end
      n_vec++;
      if (ram_addr !== m_addr || ram_wdata !== m_wdata) begin
         n_err++;
         $display("FAIL ram_bus at %0t: got addr %h data %h want addr %h data %h", $time,
                  ram_addr, ram_wdata, m_addr, m_wdata);
      end
      n_vec++;
      if (rdata0 !== m_rdata[0] || rdata1 !== m_rdata[1]) begin
         n_err++;
         $display("FAIL rdata at %0t: got %h/%h want %h/%h", $time, rdata0, rdata1,
                  m_rdata[0], m_rdata[1]);
      end
   endtask

   // Step until the DUT acks port p; cycles = -1 if the budget runs out.
   task automatic wait_ack(input int p, input int budget, output int cycles);
      cycles = -1;
      for (int c = 1; c <= budget; c++) begin
         step();
         if (ack[p] === 1'b1) begin
            cycles = c;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_ni = 1'b0;
      req    = 2'b00;
      model_reset();
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_vec++;
      if ({ack, busy, ram_wren, ram_rden} !== 5'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
         n_err++;
         $display("FAIL reset_ctl: got ctl %b addr %h data %h want all 0",
                  {ack, busy, ram_wren, ram_rden}, ram_addr, ram_wdata);
      end
      n_vec++;
      if (rdata0 !== '0 || rdata1 !== '0) begin
         n_err++;
         $display("FAIL reset_rdata: got %h/%h want 0/0", rdata0, rdata1);
      end
   endtask

   task automatic test_write_read();
      int cyc;
      we[0]  = 1'b1;
      addr0  = 4'd3;
      wdata0 = 4'hA;
      req    = 2'b01;
      step();
      n_vec++;
      if (ram_wren !== 1'b1 || ack !== 2'b01 || ram_addr !== 4'd3 || ram_wdata !== 4'hA) begin
         n_err++;
         $display("FAIL write_t1: got wren %b ack %b addr %h data %h want 1 01 3 a",
                  ram_wren, ack, ram_addr, ram_wdata);
      end
      req = 2'b00;
      step();
      we[0] = 1'b0;
      req   = 2'b01;
      wait_ack(0, 10, cyc);
      n_vec++;
      if (cyc != 3) begin
         n_err++;
         $display("FAIL read_latency: got %0d want 3", cyc);
      end
      n_vec++;
      if (rdata0 !== 4'hA) begin
         n_err++;
         $display("FAIL read_data: got %h want a", rdata0);
      end
      req = 2'b00;
      step();
   endtask

   task automatic test_rr();
      int order [4];
      int exp_order [4];
      int k = 0;
      apply_reset();
      we    = 2'b00;
      addr0 = 4'd1;
      addr1 = 4'd2;
      req   = 2'b11;
      for (int i = 0; i < 4; i++) exp_order[i] = FixedPrio ? 0 : i % 2;
      for (int c = 0; c < 40 && k < 4; c++) begin
         step();
         if (ack[0] === 1'b1) begin
            order[k] = 0;
            k++;
         end else if (ack[1] === 1'b1) begin
            order[k] = 1;
            k++;
         end
      end
      n_vec++;
      if (k != 4) begin
         n_err++;
         $display("FAIL rr_ack_count: got %0d want 4", k);
      end
      for (int i = 0; i < k; i++) begin
         n_vec++;
         if (order[i] != exp_order[i]) begin
            n_err++;
            $display("FAIL rr_order[%0d]: got port %0d want port %0d", i, order[i],
                     exp_order[i]);
         end
      end
      req = 2'b00;
      step();
   endtask

   task automatic test_cross();
      int cyc;
      logic [M-1:0] exp_r1;
      we[1]  = 1'b1;
      addr1  = 4'd15;
      wdata1 = 4'hF;
      req    = 2'b10;
      wait_ack(1, 5, cyc);
      n_vec++;
      if (cyc != 1) begin
         n_err++;
         $display("FAIL cross_write_latency: got %0d want 1", cyc);
      end
      req = 2'b00;
      step();
      exp_r1 = m_rdata[1];
      we[0]  = 1'b0;
      addr0  = 4'd15;
      req    = 2'b01;
      wait_ack(0, 10, cyc);
      n_vec++;
      if (rdata0 !== 4'hF) begin
         n_err++;
         $display("FAIL cross_rdata0: got %h want f", rdata0);
      end
      n_vec++;
      if (rdata1 !== exp_r1) begin
         n_err++;
         $display("FAIL cross_rdata1_hold: got %h want %h", rdata1, exp_r1);
      end
      req = 2'b00;
      step();
   endtask

   task automatic test_hold();
      int n_ack = 0;
      logic [7:0] busy_seq;
      we[0]  = 1'b1;
      addr0  = 4'd7;
      wdata0 = 4'h5;
      req    = 2'b01;
      for (int c = 0; c < 8; c++) begin
         step();
         busy_seq[c] = busy;
         if (ack[0] === 1'b1) n_ack++;
      end
      n_vec++;
      if (n_ack != 4) begin
         n_err++;
         $display("FAIL hold_acks: got %0d want 4", n_ack);
      end
      n_vec++;
      if (busy_seq !== 8'b0101_0101) begin
         n_err++;
         $display("FAIL hold_busy: got %b want 01010101", busy_seq);
      end
      req = 2'b00;
      step();
   endtask

   task automatic test_reset_mid();
      we[0] = 1'b0;
      addr0 = 4'd15;
      req   = 2'b01;
      step();
      step();
      rst_ni = 1'b0;
      req    = 2'b00;
      #1;
      n_vec++;
      if ({ack, busy, ram_wren, ram_rden} !== 5'b0 || ram_addr !== '0 || ram_wdata !== '0 ||
          rdata0 !== '0 || rdata1 !== '0) begin
         n_err++;
         $display("FAIL reset_mid: got ctl %b addr %h data %h rdata %h/%h want all 0",
                  {ack, busy, ram_wren, ram_rden}, ram_addr, ram_wdata, rdata0, rdata1);
      end
      model_reset();
      @(negedge clk);
      rst_ni = 1'b1;
      for (int i = 0; i < Depth; i++) begin
         n_vec++;
         if (ram_mem[i] !== m_mem[i]) begin
            n_err++;
            $display("FAIL reset_mid_ram[%0d]: got %h want %h", i, ram_mem[i], m_mem[i]);
         end
      end
      repeat (3) step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         step();
         for (int p = 0; p < 2; p++) begin
            if (m_ack[p]) begin
               if ($urandom_range(9) < 7) req[p] = 1'b0;
            end else if (!req[p] && $urandom_range(9) < 4) begin
               req[p] = 1'b1;
               we[p]  = 1'($urandom_range(1));
               if (p == 0) begin
                  addr0  = N'($urandom_range(Depth - 1));
                  wdata0 = M'($urandom());
               end else begin
                  addr1  = N'($urandom_range(Depth - 1));
                  wdata1 = M'($urandom());
               end
            end
         end
      end
      req = 2'b00;
      repeat (4) step();
   endtask

   initial begin
      rst_ni = 1'b0;
      req    = 2'b00;
      we     = 2'b00;
      addr0  = '0;
      addr1  = '0;
      wdata0 = '0;
      wdata1 = '0;
      model_reset();
      test_reset();
      test_write_read();
      test_rr();
      test_cross();
      test_hold();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
